// File: rtl/rv_pkg.sv
// rv_pkg: shared ready/valid constants and width helper for the rv_* blocks.
package rv_pkg;
  localparam int RV_DATA_W = 32;
  localparam int RV_DEPTH = 4;
  localparam int RV_AFULL_TH = 3;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction
endpackage

// File: rtl/rv_wrap_ptr.sv
// rv_wrap_ptr: index counter wrapping MAX-1 -> 0; clr input exists only with RVF_FLUSH_EN.
module rv_wrap_ptr
  import rv_pkg::*;
#(
  parameter int MAX = 4,
  localparam int PW = clog2(MAX)
) (
  input  logic          clk,
  input  logic          rst,
`ifdef RVF_FLUSH_EN
  input  logic          clr,
`endif
  input  logic          inc,
  output logic [PW-1:0] ptr
);
  logic clr_w;
`ifdef RVF_FLUSH_EN
  assign clr_w = clr;
`else
  assign clr_w = 1'b0;
`endif
  // explicit compare so non-power-of-2 depths wrap correctly
  always_ff @(posedge clk)
    if (rst || clr_w) ptr <= '0;
    else if (inc) ptr <= (ptr == PW'(MAX - 1)) ? '0 : ptr + 1'b1;
endmodule

// File: rtl/rv_fifo_buf.sv
// rv_fifo_buf: DEPTH-entry ready/valid elastic buffer; flush port added with RVF_FLUSH_EN.
module rv_fifo_buf
  import rv_pkg::*;
#(
  parameter int DATA_W = RV_DATA_W,
  parameter int DEPTH = RV_DEPTH,
  parameter int AFULL_TH = RV_AFULL_TH,
  localparam int CNT_W = clog2(DEPTH + 1),
  localparam int PTR_W = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
`ifdef RVF_FLUSH_EN
  input  logic              flush,
`endif
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  count,
  output logic              almost_full
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic push, pop, clr, wr_en, rd_en;
`ifdef RVF_FLUSH_EN
  assign clr = flush;
`else
  assign clr = 1'b0;
`endif
  // flags come from registered count only, keeping out_ready off the in_ready path
  assign in_ready = count_q != CNT_W'(DEPTH);
  assign out_valid = count_q != '0;
  assign almost_full = count_q >= CNT_W'(AFULL_TH);
  assign count = count_q;
  assign out_data = mem_q[rd_ptr];
  assign push = in_valid & in_ready;
  assign pop = out_valid & out_ready;
  assign wr_en = push & ~clr;
  assign rd_en = pop & ~clr;
  always_comb count_d = clr ? '0 : count_q + CNT_W'(wr_en) - CNT_W'(rd_en);
  always_ff @(posedge clk)
    if (rst) begin
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      count_q <= count_d;
      if (wr_en) mem_q[wr_ptr] <= in_data;
    end
  rv_wrap_ptr #(.MAX(DEPTH)) u_wr (
    .clk(clk),
    .rst(rst),
`ifdef RVF_FLUSH_EN
    .clr(clr),
`endif
    .inc(wr_en),
    .ptr(wr_ptr)
  );
  rv_wrap_ptr #(.MAX(DEPTH)) u_rd (
    .clk(clk),
    .rst(rst),
`ifdef RVF_FLUSH_EN
    .clr(clr),
`endif
    .inc(rd_en),
    .ptr(rd_ptr)
  );
endmodule

// File: tb/tb_rv_fifo_buf.sv
// tb_rv_fifo_buf: random and directed checks of rv_fifo_buf (DEPTH=4 and DEPTH=3) against queue models.
module tb_rv_fifo_buf;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic fl4 = 1'b0, fl3 = 1'b0;
  logic v4 = 1'b0, r4 = 1'b0, v3 = 1'b0, r3 = 1'b0;
  logic [31:0] d4 = '0, d3 = '0;
  logic rdy4, vld4, af4, rdy3, vld3, af3;
  logic [31:0] q4o, q3o;
  logic [2:0] cnt4;
  logic [1:0] cnt3;
  int total = 0, bad = 0;
  int m4[$];
  int m3[$];
  always #5 clk = ~clk;
  rv_fifo_buf #(.DATA_W(32), .DEPTH(4), .AFULL_TH(3)) u4 (
    .clk(clk), .rst(rst),
`ifdef RVF_FLUSH_EN
    .flush(fl4),
`endif
    .in_valid(v4), .in_ready(rdy4), .in_data(d4),
    .out_valid(vld4), .out_ready(r4), .out_data(q4o),
    .count(cnt4), .almost_full(af4)
  );
  rv_fifo_buf #(.DATA_W(32), .DEPTH(3), .AFULL_TH(2)) u3 (
    .clk(clk), .rst(rst),
`ifdef RVF_FLUSH_EN
    .flush(fl3),
`endif
    .in_valid(v3), .in_ready(rdy3), .in_data(d3),
    .out_valid(vld3), .out_ready(r3), .out_data(q3o),
    .count(cnt3), .almost_full(af3)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask
  task automatic check_all();
    chk("rdy4", 32'(rdy4), 32'(m4.size() < 4));
    chk("vld4", 32'(vld4), 32'(m4.size() > 0));
    chk("cnt4", 32'(cnt4), 32'(m4.size()));
    chk("af4", 32'(af4), 32'(m4.size() >= 3));
    if (m4.size() > 0) chk("dat4", q4o, m4[0]);
    chk("rdy3", 32'(rdy3), 32'(m3.size() < 3));
    chk("vld3", 32'(vld3), 32'(m3.size() > 0));
    chk("cnt3", 32'(cnt3), 32'(m3.size()));
    chk("af3", 32'(af3), 32'(m3.size() >= 2));
    if (m3.size() > 0) chk("dat3", q3o, m3[0]);
  endtask
  task automatic step(input logic iv4, input logic [31:0] id4, input logic or4,
                      input logic iv3, input logic [31:0] id3, input logic or3,
                      input logic rs, input logic fl);
    bit p4, p3, o4, o3;
    check_all();
    v4 = iv4; d4 = id4; r4 = or4; v3 = iv3; d3 = id3; r3 = or3; rst = rs;
    fl4 = fl; fl3 = fl;
    p4 = iv4 && m4.size() < 4;
    o4 = or4 && m4.size() > 0;
    p3 = iv3 && m3.size() < 3;
    o3 = or3 && m3.size() > 0;
    @(posedge clk);
`ifdef RVF_FLUSH_EN
    if (rs || fl) begin
`else
    if (rs) begin
`endif
      m4.delete();
      m3.delete();
    end else begin
      if (o4) void'(m4.pop_front());
      if (p4) m4.push_back(int'(id4));
      if (o3) void'(m3.pop_front());
      if (p3) m3.push_back(int'(id3));
    end
    #1;
    v4 = 0; r4 = 0; v3 = 0; r3 = 0; rst = 0; fl4 = 0; fl3 = 0;
  endtask
  initial begin
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    chk("rst_dat4", q4o, 0);
    chk("rst_dat3", q3o, 0);
    for (int i = 0; i < 4; i++) step(1, 32'hA0 + i, 0, 0, 0, 0, 0, 0);
    step(1, 32'hA4, 0, 0, 0, 0, 0, 0);
    chk("full_cnt", 32'(cnt4), 4);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0, 0, 0, 0);
    chk("drained", 32'(vld4), 0);
    for (int i = 0; i < 20; i++) step(0, 0, 0, 1, i, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 1000; i++)
      step(1'($urandom), $urandom, 1'($urandom), 1'($urandom), $urandom, 1'($urandom), 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    step(1, 32'h11, 0, 1, 32'h31, 0, 0, 0);
    step(1, 32'h12, 0, 1, 32'h32, 0, 0, 0);
    step(1, 32'h13, 0, 1, 32'h33, 0, 1, 0);
    chk("mid_rst_cnt", 32'(cnt4), 0);
    step(1, 32'h14, 0, 1, 32'h34, 0, 0, 0);
    step(0, 0, 1, 0, 0, 1, 0, 0);
`ifdef RVF_FLUSH_EN
    step(1, 32'h21, 0, 1, 32'h41, 0, 0, 0);
    step(1, 32'h22, 0, 1, 32'h42, 0, 0, 0);
    step(1, 32'h23, 0, 1, 32'h43, 0, 0, 1);
    chk("flush_cnt", 32'(cnt4), 0);
    step(1, 32'h24, 0, 1, 32'h44, 0, 0, 0);
    step(0, 0, 1, 0, 0, 1, 0, 0);
`endif
    check_all();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rv_fifo_buf.md
Name: rv_fifo_buf

Overview:
- Parametrised ready/valid elastic buffer; successor to the single-entry pipeline register.
- Generalises storage to DEPTH entries with occupancy reporting and an almost-full flag.
- in_ready is derived only from registered state, so there is no combinational path from out_ready to in_ready. Stages can chain without long ready paths.
- Sits between producer and consumer pipeline stages anywhere a single register stage cannot absorb backpressure.

Parameters:
- DATA_W, 32, payload width in bits (>=1)
- DEPTH, 4, number of storage entries (>=2; need not be a power of 2)
- AFULL_TH, 3, almost_full asserts when count >= AFULL_TH (1..DEPTH)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  producer has data
- in_ready  out  1  buffer can accept; registered-state only
- in_data  in  DATA_W  producer payload
- out_valid  out  1  buffer holds at least one entry
- out_ready  in  1  consumer accepts
- out_data  out  DATA_W  oldest entry
- count  out  CNT_W  occupancy 0..DEPTH; CNT_W = clog2(DEPTH+1)
- almost_full  out  1  count >= AFULL_TH
- flush  in  1  present only with RVF_FLUSH_EN; see Optional Feature

Behaviour:
- Reset state:
  - Reset is synchronous and active-high; clock is clk.
  - rst=1 at a rising edge sets rd_ptr=0, wr_ptr=0, count=0, and clears all storage entries to 0.
  - Outputs after reset: in_ready=1, out_valid=0, out_data=0, almost_full=0 (AFULL_TH>=1).
- Handshakes:
  - push = in_valid & in_ready; pop = out_valid & out_ready.
  - in_valid may assert regardless of in_ready; data transfers only on push.
- Flags:
  - in_ready = (count != DEPTH).
  - out_valid = (count != 0).
  - almost_full = (count >= AFULL_TH).
  - All flags are functions of registered count only.
- Datapath:
  - out_data = mem[rd_ptr], combinational read of registered storage.
  - out_data is only checked when out_valid=1.
- Push: writes mem[wr_ptr] <= in_data and advances wr_ptr.
- Pop: advances rd_ptr.
- Pointer wrap: both pointers wrap from DEPTH-1 to 0. Explicit compare, not modulo-2^n, because DEPTH may be a non-power-of-2.
- count update:
  - push only: +1
  - pop only: -1
  - both or neither: unchanged
- Latency: data pushed into an empty buffer appears on out_data with out_valid=1 in the next cycle. There is no same-cycle bypass.
- Throughput: one push and one pop per cycle sustained whenever 0 < count < DEPTH.
- Boundary conditions:
  - Full (count==DEPTH): in_ready=0, so a push in the same cycle as a pop is refused. The freed slot becomes available the following cycle, giving a one-cycle bubble at full.
  - Empty: out_valid=0 and out_ready is ignored; count never underflows.
  - Simultaneous push and pop at count==1: count stays 1 and the new data becomes the head next cycle.
  - Reset mid-operation: all contents are discarded and the next cycle is identical to the post-reset state.
- Ordering: strict FIFO; no entry is dropped or duplicated.

Optional Feature:
- Macro: RVF_FLUSH_EN.
- Defined:
  - Adds the flush input.
  - flush=1 at an edge clears the pointers and count like rst, but does not clear storage contents.
  - flush takes priority over push and pop in the same cycle; data offered that cycle is not stored even though in_ready may read 1.
- Undefined: no flush port; the block is otherwise identical.

Decomposition:
- Package rv_pkg:
  - clog2 function used to derive CNT_W and the pointer width.
  - Shared ready/valid localparams, reused by other rv_* blocks.
- Sub-module rv_wrap_ptr:
  - Parameter MAX; inputs clk, rst, inc (and clr under RVF_FLUSH_EN); output ptr.
  - Wraps MAX-1 -> 0.
  - Instantiated twice, once for wr_ptr and once for rd_ptr.

Test Plan:
- Reset:
  - Stimulus: hold rst=1 for 2 cycles, then release.
  - Required: in_ready=1, out_valid=0, count=0, almost_full=0, out_data=0.
- Fill to full (DEPTH=4, AFULL_TH=3):
  - Stimulus: push 0xA0..0xA3 with out_ready=0.
  - Required: count steps 1,2,3,4; almost_full=1 from count 3; in_ready=0 at count 4.
  - Then: a fifth in_valid with 0xA4 is not accepted.
- Drain order:
  - Stimulus: from full, set out_ready=1.
  - Required: out_data shows 0xA0,0xA1,0xA2,0xA3 on consecutive cycles; out_valid=0 after the fourth pop; count=0.
- Streaming with non-power-of-2 depth (DEPTH=3):
  - Stimulus: continuous in_valid/out_ready=1 for 20 beats of values 0..19.
  - Required: output sequence 0..19 with no gaps after the first-cycle latency; pointers wrap 2 -> 0 correctly.
- Random backpressure:
  - Stimulus: 1000 beats, in_valid and out_ready randomised at 50%.
  - Required: scoreboard matches in order; count always equals pushes minus pops and stays within 0..DEPTH.
- Reset and flush mid-stream:
  - Stimulus: with 2 entries held, pulse rst (and separately flush under RVF_FLUSH_EN) together with in_valid=1.
  - Required: count=0 and out_valid=0 next cycle; the offered data is discarded.
